// File: rtl/stream_select_packer_pkg.sv
// Shared constants and helpers for the pixel-stream select/pack output stage.
package stream_select_packer_pkg;

  localparam int UART_WORD_W = 8;

  // Counter/select width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_select_packer_pack_accum.sv
// Insert-style pixel accumulator with word and line position counters.
module stream_select_packer_pack_accum
  import stream_select_packer_pkg::*;
#(
  parameter int pixel_width_p  = 1,
  parameter int word_width_p   = UART_WORD_W,
  parameter int linewidth_px_p = 320
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     accept_i,
  input  logic [pixel_width_p-1:0] pix_i,
  output logic                     complete_o,
  output logic [word_width_p-1:0]  word_o,
  output logic                     line_start_o
);

  localparam int pack_num_lp = word_width_p / pixel_width_p;
  localparam int wcnt_w_lp   = clog2_min1(pack_num_lp);
  localparam int lcnt_w_lp   = clog2_min1(linewidth_px_p);

  logic [word_width_p-1:0] acc_q, acc_d;
  logic [wcnt_w_lp-1:0]    word_cnt_q, word_cnt_d;
  logic [lcnt_w_lp-1:0]    line_cnt_q, line_cnt_d;
  logic                    line_end;

  assign line_end     = (line_cnt_q == lcnt_w_lp'(linewidth_px_p - 1));
  assign complete_o   = line_end || (word_cnt_q == wcnt_w_lp'(pack_num_lp - 1));
  assign line_start_o = (line_cnt_q == '0) && (word_cnt_q == '0);

  // Slots above word_cnt are always zero, so a line-end word comes out padded.
  always_comb begin
    word_o = acc_q;
    word_o[word_cnt_q*pixel_width_p +: pixel_width_p] = pix_i;
    acc_d      = acc_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    if (accept_i) begin
      acc_d      = complete_o ? '0 : word_o;
      word_cnt_d = complete_o ? '0 : word_cnt_q + 1'b1;
      line_cnt_d = line_end   ? '0 : line_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q      <= '0;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
    end
  end

endmodule

// File: rtl/stream_select_packer.sv
// Line-synchronous channel select feeding a pixel packer and a one-word output register.
module stream_select_packer
  import stream_select_packer_pkg::*;
#(
  parameter int  channels_p     = 4,
  parameter int  pixel_width_p  = 1,
  parameter int  word_width_p   = UART_WORD_W,
  parameter int  linewidth_px_p = 320,
  localparam int sel_width_lp   = clog2_min1(channels_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_ni,
  input  logic [sel_width_lp-1:0]             sel_i,
  input  logic [channels_p-1:0]               valid_i,
  input  logic [channels_p*pixel_width_p-1:0] data_i,
  output logic [channels_p-1:0]               ready_o,
  output logic                                valid_o,
  output logic [word_width_p-1:0]             data_o,
  input  logic                                ready_i,
  output logic [sel_width_lp-1:0]             sel_o
);

  logic [sel_width_lp-1:0]  sel_q;
  logic                     valid_q;
  logic [word_width_p-1:0]  data_q;
  logic [pixel_width_p-1:0] pix;
  logic [word_width_p-1:0]  word;
  logic                     sel_ready, accept, complete, line_start;

  assign pix       = data_i[sel_q*pixel_width_p +: pixel_width_p];
  // Stall only the pixel that would need a second output slot.
  assign sel_ready = !valid_q || ready_i || !complete;
  assign accept    = valid_i[sel_q] && sel_ready;

  for (genvar c = 0; c < channels_p; c++) begin : g_rdy
    assign ready_o[c] = (sel_q == sel_width_lp'(c)) ? sel_ready : 1'b1;
  end

  stream_select_packer_pack_accum #(
    .pixel_width_p (pixel_width_p),
    .word_width_p  (word_width_p),
    .linewidth_px_p(linewidth_px_p)
  ) u_acc (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .accept_i    (accept),
    .pix_i       (pix),
    .complete_o  (complete),
    .word_o      (word),
    .line_start_o(line_start)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (line_start && !accept && (int'(sel_i) < channels_p)) sel_q <= sel_i;
      if (accept && complete) begin
        valid_q <= 1'b1;
        data_q  <= word;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign sel_o   = sel_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_stream_select_packer.sv
// Directed and scoreboarded checks of the select/pack stage on two parameterisations.
module tb_stream_select_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // A: 1-bit pixels, 12-pixel lines
  logic [1:0] a_sel, a_so;
  logic [3:0] a_vld, a_rdy, a_dat;
  logic       a_vo, a_ri;
  logic [7:0] a_do;

  // B: 2-bit pixels, 6-pixel lines
  logic [1:0] b_sel, b_so;
  logic [3:0] b_vld, b_rdy;
  logic [7:0] b_dat, b_do;
  logic       b_vo, b_ri;

  stream_select_packer #(.channels_p(4), .pixel_width_p(1), .word_width_p(8), .linewidth_px_p(12)) u_a (
    .clk_i(clk), .reset_ni(rst_n), .sel_i(a_sel), .valid_i(a_vld), .data_i(a_dat),
    .ready_o(a_rdy), .valid_o(a_vo), .data_o(a_do), .ready_i(a_ri), .sel_o(a_so));

  stream_select_packer #(.channels_p(4), .pixel_width_p(2), .word_width_p(8), .linewidth_px_p(6)) u_b (
    .clk_i(clk), .reset_ni(rst_n), .sel_i(b_sel), .valid_i(b_vld), .data_i(b_dat),
    .ready_o(b_rdy), .valid_o(b_vo), .data_o(b_do), .ready_i(b_ri), .sel_o(b_so));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_vld = '0; a_dat = '0; b_vld = '0; b_dat = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic push_a(input int ch, input logic pix);
    a_vld = '0; a_dat = '0;
    a_vld[ch] = 1'b1;
    a_dat[ch] = pix;
    cyc();
    a_vld = '0;
  endtask

  task automatic push_b(input int ch, input logic [1:0] pix);
    b_vld = '0; b_dat = '0;
    b_vld[ch] = 1'b1;
    b_dat[ch*2 +: 2] = pix;
    cyc();
    b_vld = '0;
  endtask

  logic [7:0]  pat;
  logic [11:0] line;
  logic [7:0]  mw;
  logic [31:0] expw;
  logic        acc, mcomp;
  int          idx, mk, ml, pix_acc, words_out, ncyc;
  logic [7:0]  exp_q[$];

  initial begin
    a_sel = 2'd0; a_ri = 1'b1; b_sel = 2'd1; b_ri = 1'b1;
    do_reset();

    // reset state
    chk("rst_sel", a_so, 2'd0);
    chk("rst_valid", a_vo, 1'b0);
    chk("rst_data", a_do, 8'h00);

    // one full word, latency 1
    pat = 8'h8D;
    for (int k = 0; k < 7; k++) push_a(0, pat[k]);
    chk("t1_no_early", a_vo, 1'b0);
    push_a(0, pat[7]);
    chk("t1_valid", a_vo, 1'b1);
    chk("t1_data", a_do, 8'h8D);
    cyc();
    chk("t1_drain", a_vo, 1'b0);

    // full line of ones: one full word then zero-padded flush
    do_reset();
    for (int k = 0; k < 8; k++) push_a(0, 1'b1);
    chk("t2_w0_valid", a_vo, 1'b1);
    chk("t2_w0_data", a_do, 8'hFF);
    for (int k = 0; k < 4; k++) push_a(0, 1'b1);
    chk("t2_w1_valid", a_vo, 1'b1);
    chk("t2_w1_data", a_do, 8'h0F);
    chk("t2_line_cnt", u_a.u_acc.line_cnt_q, 0);

    // select change mid-line waits for line end
    do_reset();
    for (int k = 0; k < 5; k++) push_a(0, 1'b1);
    a_sel = 2'd3;
    for (int k = 0; k < 7; k++) begin
      a_vld = 4'hF; a_dat = 4'b0101;
      #3;
      chk("t3_unsel_rdy", {a_rdy[2], a_rdy[1]}, 2'b11);
      chk("t3_sel_hold", a_so, 2'd0);
      cyc();
    end
    a_vld = '0;
    chk("t3_sel_at_end", a_so, 2'd0);
    chk("t3_flush", a_do, 8'h0F);
    cyc();
    chk("t3_sel_new", a_so, 2'd3);
    chk("t3_all_rdy", a_rdy, 4'hF);

    // backpressure: one word held, partial in accumulator, completing pixel stalled
    a_sel = 2'd0;
    do_reset();
    a_ri = 1'b0;
    line = {4'h9, 8'hA5};
    idx = 0;
    for (int k = 0; k < 20; k++) begin
      a_vld = 4'b0001;
      a_dat = {3'b000, (idx < 12) ? line[idx] : 1'b0};
      #3;
      acc = a_rdy[0];
      cyc();
      if (acc) idx++;
    end
    a_vld = 4'b0001;
    a_dat = {3'b000, line[11]};
    #3;
    chk("t4_accepted", idx, 11);
    chk("t4_stall_rdy", a_rdy[0], 1'b0);
    chk("t4_held_valid", a_vo, 1'b1);
    chk("t4_held_data", a_do, 8'hA5);
    a_ri = 1'b1;
    #1;
    chk("t4_release_rdy", a_rdy[0], 1'b1);
    cyc();
    a_vld = '0;
    chk("t4_w1_valid", a_vo, 1'b1);
    chk("t4_w1_data", a_do, 8'h09);
    cyc();
    chk("t4_empty", a_vo, 1'b0);

    // reset mid-word discards partial and clears select
    a_sel = 2'd2;
    do_reset();
    cyc();
    chk("t5_sel2", a_so, 2'd2);
    a_ri = 1'b0;
    for (int k = 0; k < 11; k++) push_a(2, 1'b1);
    chk("t5_pre_valid", a_vo, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", a_vo, 1'b0);
    chk("t5_rst_sel", a_so, 2'd0);
    chk("t5_rst_data", a_do, 8'h00);
    a_sel = 2'd0;
    cyc();
    rst_n = 1'b1;
    a_ri = 1'b1;
    cyc();
    pat = 8'h3C;
    for (int k = 0; k < 8; k++) push_a(0, pat[k]);
    chk("t5_post_valid", a_vo, 1'b1);
    chk("t5_post_data", a_do, 8'h3C);

    // 2-bit pixels 3,0,1,2 on channel 1
    do_reset();
    chk("t6_sel1", b_so, 2'd1);
    push_b(1, 2'd3); push_b(1, 2'd0); push_b(1, 2'd1); push_b(1, 2'd2);
    chk("t6_valid", b_vo, 1'b1);
    chk("t6_data", b_do, 8'h93);

    // random valid/ready scoreboard, 10 lines of 6 pixels
    do_reset();
    mw = '0; mk = 0; ml = 0; pix_acc = 0; words_out = 0; ncyc = 0;
    while (ncyc < 3000 && (pix_acc < 60 || exp_q.size() > 0)) begin
      b_vld = 4'($urandom);
      b_dat = 8'($urandom);
      if (pix_acc >= 60) b_vld[1] = 1'b0;
      b_ri = ($urandom_range(0, 9) < 7);
      #3;
      mcomp = (mk == 3) || (ml == 5);
      chk("r_unsel_rdy", {b_rdy[3:2], b_rdy[0]}, 3'b111);
      chk("r_sel_rdy", b_rdy[1], !b_vo || b_ri || !mcomp);
      if (b_vo && b_ri) begin
        expw = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD;
        chk("r_word", {24'h0, b_do}, expw);
        words_out++;
      end
      if (b_vld[1] && b_rdy[1]) begin
        mw[mk*2 +: 2] = b_dat[3:2];
        if (mcomp) begin
          exp_q.push_back(mw);
          mw = '0;
          mk = 0;
        end else begin
          mk++;
        end
        ml = (ml == 5) ? 0 : ml + 1;
        pix_acc++;
      end
      cyc();
      ncyc++;
    end
    b_vld = '0;
    chk("r_pixels", pix_acc, 60);
    chk("r_words", words_out, 20);
    chk("r_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
